// File: rtl/lsb_mem_executor_pkg.sv
// Shared opcode encodings, address map and FSM state type for the commit-side
// memory executor and its helpers.
package lsb_mem_executor_pkg;

  localparam logic [31:0] IO_BASE_ADDR = 32'h0003_0000;

  // Loads are contiguous, then stores; the ROB relies on the same ranges.
  localparam logic [5:0] OP_LB  = 6'd1;
  localparam logic [5:0] OP_LH  = 6'd2;
  localparam logic [5:0] OP_LW  = 6'd3;
  localparam logic [5:0] OP_LBU = 6'd4;
  localparam logic [5:0] OP_LHU = 6'd5;
  localparam logic [5:0] OP_SB  = 6'd6;
  localparam logic [5:0] OP_SH  = 6'd7;
  localparam logic [5:0] OP_SW  = 6'd8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_GNT,
    ST_ACCESS,
    ST_DONE
  } state_t;

  function automatic logic is_mem_op(input logic [5:0] op);
    return (op >= OP_LB) && (op <= OP_SW);
  endfunction

  function automatic logic is_store(input logic [5:0] op);
    return (op >= OP_SB) && (op <= OP_SW);
  endfunction

  function automatic logic [2:0] byte_count(input logic [5:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return 3'd1;
      OP_LH, OP_LHU, OP_SH: return 3'd2;
      default:              return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/lsb_mem_executor_load_extender.sv
// Turns the little-endian bytes gathered by a load into the register value:
// sign- or zero-extended for sub-word loads, zero for stores.
module lsb_mem_executor_load_extender
  import lsb_mem_executor_pkg::*;
(
  input  logic [5:0]  opcode,
  input  logic [31:0] raw,
  output logic [31:0] result
);

  always_comb begin
    result = '0;
    case (opcode)
      OP_LB:   result = {{24{raw[7]}}, raw[7:0]};
      OP_LH:   result = {{16{raw[15]}}, raw[15:0]};
      OP_LW:   result = raw;
      OP_LBU:  result = {24'd0, raw[7:0]};
      OP_LHU:  result = {16'd0, raw[15:0]};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/lsb_mem_executor.sv
// Commit-side load/store executor: runs one ROB-head memory op bytewise over
// the arbitrated RAM/IO port and returns a one-cycle completion.
module lsb_mem_executor
  import lsb_mem_executor_pkg::*;
#(
  parameter logic [31:0] IO_BASE = IO_BASE_ADDR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        req_valid,
  input  logic [5:0]  req_rob_index,
  input  logic [5:0]  req_opcode,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_s_val,
  output logic        busy,
  output logic        done_valid,
  output logic [5:0]  done_rob_index,
  output logic [31:0] done_l_data,
  output logic        mem_req,
  input  logic        mem_gnt,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  output logic [7:0]  mem_dout,
  input  logic [7:0]  mem_din,
  input  logic        io_buffer_full
);

  state_t      state;
  state_t      next_state;
  logic [5:0]  rob_index;
  logic [5:0]  opcode;
  logic [31:0] addr;
  logic [31:0] s_val;
  logic [2:0]  n_bytes;
  logic [2:0]  k;
  logic [31:0] data;
  logic [31:0] ext_data;
  logic        store_op;
  logic        io_target;
  logic        write_cycle;
  logic        accept;
  logic [1:0]  cap_slot;
  logic [31:0] byte_addr;

  assign store_op    = is_store(opcode);
  assign io_target   = (addr >= IO_BASE);
  assign byte_addr   = addr + {29'd0, k};
  assign write_cycle = (state == ST_ACCESS) && store_op && !(io_target && io_buffer_full);
  assign accept      = (state == ST_IDLE) && req_valid && is_mem_op(req_opcode);
  // Read data lags its address by one cycle, so cycle k captures byte k-1.
  assign cap_slot    = k[1:0] - 2'd1;

  lsb_mem_executor_load_extender load_extender (
    .opcode (opcode),
    .raw    (data),
    .result (ext_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      rob_index <= '0;
      opcode    <= '0;
      addr      <= '0;
      s_val     <= '0;
      n_bytes   <= '0;
      k         <= '0;
      data      <= '0;
    end else if (rdy) begin
      state <= next_state;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            rob_index <= req_rob_index;
            opcode    <= req_opcode;
            addr      <= req_addr;
            s_val     <= req_s_val;
            n_bytes   <= byte_count(req_opcode);
            k         <= '0;
            data      <= '0;
          end
        end
        ST_ACCESS: begin
          if (store_op) begin
            if (write_cycle) k <= k + 3'd1;
          end else begin
            if (k != 3'd0) data[{cap_slot, 3'b000} +: 8] <= mem_din;
            k <= k + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    next_state  = state;
    busy        = (state != ST_IDLE);
    mem_req     = 1'b0;
    mem_a       = '0;
    mem_wr      = 1'b0;
    mem_dout    = '0;
    done_valid  = 1'b0;
    done_l_data = '0;
    case (state)
      ST_IDLE: begin
        if (accept) next_state = ST_WAIT_GNT;
      end
      ST_WAIT_GNT: begin
        mem_req = 1'b1;
        mem_a   = addr;
        if (mem_gnt) next_state = ST_ACCESS;
      end
      ST_ACCESS: begin
        mem_req = 1'b1;
        mem_a   = byte_addr;
        if (store_op) begin
          mem_wr   = write_cycle;
          mem_dout = s_val[{k[1:0], 3'b000} +: 8];
          if (write_cycle && (k == n_bytes - 3'd1)) next_state = ST_DONE;
        end else if (k == n_bytes) begin
          next_state = ST_DONE;
        end
      end
      ST_DONE: begin
        done_valid  = 1'b1;
        done_l_data = ext_data;
        next_state  = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  assign done_rob_index = rob_index;

endmodule

// File: tb/tb_lsb_mem_executor.sv
// Randomized bench for lsb_mem_executor: a byte-addressed memory, an arbiter
// granting after a chosen delay and an IO sink that can be held full.
module tb_lsb_mem_executor;
  import lsb_mem_executor_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b1;
  logic        req_valid = 1'b0;
  logic [5:0]  req_rob_index = '0;
  logic [5:0]  req_opcode = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_s_val = '0;
  logic        busy;
  logic        done_valid;
  logic [5:0]  done_rob_index;
  logic [31:0] done_l_data;
  logic        mem_req;
  logic        mem_gnt = 1'b0;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic [7:0]  mem_dout;
  logic [7:0]  mem_din = '0;
  logic        io_buffer_full = 1'b0;

  int checks = 0;
  int errors = 0;
  int badWr = 0;
  logic [7:0]  mem [logic [31:0]];
  logic [39:0] writeLog [$];

  lsb_mem_executor dut (
    .clk            (clk),
    .rst            (rst),
    .rdy            (rdy),
    .req_valid      (req_valid),
    .req_rob_index  (req_rob_index),
    .req_opcode     (req_opcode),
    .req_addr       (req_addr),
    .req_s_val      (req_s_val),
    .busy           (busy),
    .done_valid     (done_valid),
    .done_rob_index (done_rob_index),
    .done_l_data    (done_l_data),
    .mem_req        (mem_req),
    .mem_gnt        (mem_gnt),
    .mem_a          (mem_a),
    .mem_wr         (mem_wr),
    .mem_dout       (mem_dout),
    .mem_din        (mem_din),
    .io_buffer_full (io_buffer_full)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  // Memory and IO sink share the port; everything freezes when rdy is low.
  always @(posedge clk) begin
    if (rdy) begin
      if (mem_wr) begin
        if (!mem_gnt) badWr++;
        mem[mem_a] = mem_dout;
        writeLog.push_back({mem_a, mem_dout});
      end
      mem_din <= rd(mem_a);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // One enabled clock edge, optionally preceded by frozen (rdy=0) edges.
  task automatic tick(input bit noise);
    bit en;
    do begin
      en = noise ? ($urandom_range(0, 3) != 0) : 1'b1;
      rdy = en;
      @(posedge clk);
      #1;
    end while (!en);
    rdy = 1'b1;
  endtask

  task automatic applyStimulus(input logic [5:0] op, input logic [31:0] a, input logic [31:0] sv,
                               input int g, input int s, input bit noise);
    int n, lat, doneAt, logStart;
    bit st, io;
    logic [31:0] raw, expData;
    logic [5:0] idx;
    st = (op >= OP_SB);
    n = (op == OP_LB || op == OP_LBU || op == OP_SB) ? 1 :
        (op == OP_LH || op == OP_LHU || op == OP_SH) ? 2 : 4;
    io = st && (a >= 32'h0003_0000);
    raw = '0;
    for (int i = 0; i < n; i++) raw[8*i +: 8] = rd(a + i);
    case (op)
      OP_LB:   expData = {{24{raw[7]}}, raw[7:0]};
      OP_LH:   expData = {{16{raw[15]}}, raw[15:0]};
      OP_LW:   expData = raw;
      OP_LBU:  expData = {24'd0, raw[7:0]};
      OP_LHU:  expData = {16'd0, raw[15:0]};
      default: expData = '0;
    endcase
    lat = n + (st ? 2 : 3) + g + (io ? s : 0);
    logStart = writeLog.size();
    badWr = 0;
    idx = 6'($urandom_range(0, 63));
    req_valid = 1'b1;
    req_rob_index = idx;
    req_opcode = op;
    req_addr = a;
    req_s_val = sv;
    mem_gnt = 1'b0;
    io_buffer_full = 1'($urandom_range(0, 1));
    tick(noise);
    req_valid = 1'b0;
    req_opcode = 6'($urandom);
    req_addr = $urandom;
    req_s_val = $urandom;
    doneAt = -1;
    for (int step = 1; step <= 60; step++) begin
      if (done_valid) begin
        doneAt = step;
        break;
      end
      mem_gnt = mem_req && (step >= 1 + g);
      io_buffer_full = io ? ((step >= 2 + g) && (step < 2 + g + s)) : 1'($urandom_range(0, 1));
      tick(noise);
    end
    checkOutput("latency", doneAt, lat);
    if (doneAt >= 0) begin
      checkOutput("done_index", {26'd0, done_rob_index}, {26'd0, idx});
      checkOutput("done_data", done_l_data, expData);
    end
    mem_gnt = 1'b0;
    io_buffer_full = 1'b0;
    tick(noise);
    checkOutput("done_single", {31'd0, done_valid}, 32'd0);
    checkOutput("idle_after", {31'd0, busy}, 32'd0);
    checkOutput("wr_count", writeLog.size() - logStart, st ? n : 0);
    if (st) begin
      for (int i = 0; i < n; i++) begin
        if (logStart + i < writeLog.size()) begin
          checkOutput("wr_addr", writeLog[logStart + i][39:8], a + i);
          checkOutput("wr_byte", {24'd0, writeLog[logStart + i][7:0]}, {24'd0, sv[8*i +: 8]});
        end
      end
    end
    checkOutput("wr_no_gnt", badWr, 0);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd0);
    checkOutput({tag, "_done"}, {31'd0, done_valid}, 32'd0);
    checkOutput({tag, "_req"}, {31'd0, mem_req}, 32'd0);
    checkOutput({tag, "_wr"}, {31'd0, mem_wr}, 32'd0);
    checkOutput({tag, "_a"}, mem_a, 32'd0);
    checkOutput({tag, "_dout"}, {24'd0, mem_dout}, 32'd0);
    checkOutput({tag, "_idx"}, {26'd0, done_rob_index}, 32'd0);
    checkOutput({tag, "_data"}, done_l_data, 32'd0);
  endtask

  task automatic resetMidStore();
    int logSize, sawDone;
    req_valid = 1'b1;
    req_rob_index = 6'd17;
    req_opcode = OP_SW;
    req_addr = 32'h300;
    req_s_val = 32'hCAFEF00D;
    tick(1'b0);
    req_valid = 1'b0;
    mem_gnt = mem_req;
    tick(1'b0);
    mem_gnt = mem_req;
    tick(1'b0);
    mem_gnt = mem_req;
    rst = 1'b1;
    tick(1'b0);
    checkResetOutputs("rst_mid");
    logSize = writeLog.size();
    rst = 1'b0;
    mem_gnt = 1'b0;
    sawDone = 0;
    for (int i = 0; i < 6; i++) begin
      if (done_valid) sawDone++;
      tick(1'b0);
    end
    checkOutput("rst_no_done", sawDone, 0);
    checkOutput("rst_no_wr", writeLog.size() - logSize, 0);
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    tick(1'b0);
    tick(1'b0);
    checkResetOutputs("reset");
    rst = 1'b0;
    tick(1'b0);

    $display("[TB] directed cases");
    mem[32'h100] = 8'h78;
    mem[32'h101] = 8'h56;
    mem[32'h102] = 8'h34;
    mem[32'h103] = 8'h12;
    applyStimulus(OP_LW, 32'h100, 32'h0, 0, 0, 1'b0);
    mem[32'h101] = 8'h80;
    applyStimulus(OP_LB, 32'h101, 32'h0, 0, 0, 1'b0);
    applyStimulus(OP_LBU, 32'h101, 32'h0, 0, 0, 1'b0);
    applyStimulus(OP_SH, 32'h200, 32'hABCD1234, 0, 0, 1'b0);
    applyStimulus(OP_SB, 32'h0003_0000, 32'h5A, 0, 5, 1'b0);
    applyStimulus(OP_LW, 32'h100, 32'h0, 3, 0, 1'b0);
    applyStimulus(OP_LH, 32'hFFFF_FFFF, 32'h0, 1, 0, 1'b0);

    req_valid = 1'b1;
    req_opcode = 6'd0;
    tick(1'b0);
    req_opcode = 6'd9;
    tick(1'b0);
    req_valid = 1'b0;
    checkOutput("bad_op_busy", {31'd0, busy}, 32'd0);
    checkOutput("bad_op_req", {31'd0, mem_req}, 32'd0);

    resetMidStore();
    applyStimulus(OP_LW, 32'h100, 32'h0, 0, 0, 1'b0);

    $display("[TB] random cases");
    for (int t = 0; t < 40; t++) begin
      logic [5:0] op;
      logic [31:0] a;
      int region;
      op = OP_LB + 6'($urandom_range(0, 7));
      region = $urandom_range(0, 2);
      if (region == 0) a = $urandom_range(0, 32'hFFF);
      else if (region == 1) a = 32'h0003_0000 + $urandom_range(0, 255);
      else a = 32'hFFFF_FFFC + $urandom_range(0, 3);
      applyStimulus(op, a, $urandom, $urandom_range(0, 3), $urandom_range(0, 4), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsb_mem_executor.md
# lsb_mem_executor

Commit-side memory executor for the out-of-order core. It takes the single load/store request the reorder buffer issues when a memory op reaches the ROB head, and performs it over the byte-wide RAM/IO port through the memory arbiter. It then returns a one-cycle completion carrying the ROB index and the extended load data, which the ROB uses to retire the entry. It is the responder end of the ROB↔LSB commit interface.

## Interface

Parameters:
- IO_BASE, 32'h0003_0000, addresses ≥ IO_BASE are memory-mapped IO (stores stall on io_buffer_full)

Ports (clock and reset first; reset rst, synchronous, active-high; clock clk):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rdy  in  1  global enable; when 0, all state holds
- req_valid  in  1  request pulse from ROB
- req_rob_index  in  6  ROB entry of request
- req_opcode  in  6  LB..SW opcode
- req_addr  in  32  effective address
- req_s_val  in  32  store data
- busy  out  1  op in progress; ROB must not pulse req_valid
- done_valid  out  1  completion pulse
- done_rob_index  out  6  echoed index
- done_l_data  out  32  extended load data; 0 for stores
- mem_req  out  1  memory port request to arbiter
- mem_gnt  in  1  arbiter grant; once given, held until mem_req drops
- mem_a  out  32  byte address
- mem_wr  out  1  1 = write
- mem_dout  out  8  write byte
- mem_din  in  8  read byte, valid the cycle after its address
- io_buffer_full  in  1  IO sink full

## Operation

- States: IDLE, WAIT_GNT, ACCESS, DONE.
- IDLE: on req_valid, latch index/opcode/addr/s_val; set byte count N (1 for B/BU, 2 for H/HU, 4 for W); k=0; go to WAIT_GNT. busy=1 from the next cycle until DONE exits.
- WAIT_GNT: mem_req=1, mem_a=addr, mem_wr=0; on mem_gnt go to ACCESS.
- ACCESS, load: cycle k drives mem_a=addr+k for k<N. The byte from mem_din in cycle k+1 goes to data[8k+7:8k] (little-endian). After byte N-1 is captured, go to DONE.
- ACCESS, store: cycle k drives mem_wr=1, mem_a=addr+k, mem_dout=s_val[8k+7:8k]. After the Nth write, go to DONE.
- IO store (addr ≥ IO_BASE): a write cycle occurs only when io_buffer_full=0. Otherwise mem_wr=0 and k holds.
- DONE: done_valid=1 for exactly one cycle. done_l_data is sign-extended for LB/LH, zero-extended for LBU/LHU, and raw for LW. mem_req drops. Return to IDLE.
- Address arithmetic is 32-bit wrap; misaligned accesses are legal and are split bytewise with no trap.
- req_valid while busy is a protocol violation (bench assertion); the request is ignored.
- Opcodes outside LB..SW are ignored in IDLE.

## Timing

- Reset: state IDLE; busy, done_valid, mem_req, mem_wr = 0; mem_a, mem_dout, done_rob_index, done_l_data = 0.
- rst mid-access aborts immediately: no further writes, no done pulse.
- With gnt granted in the first WAIT_GNT cycle: load latency req→done = N+3 cycles; store latency = N+2 cycles, plus one per IO stall cycle.
- Outside a write cycle, mem_wr=0 always, and it is never asserted without a grant.
- done_valid and a new req_valid in the same cycle are allowed. The ROB's next request is issued in response to done, so it arrives in IDLE.
- rdy=0 freezes the state, counters and all outputs. A byte returning during the freeze is re-sampled; the memory model holds mem_din while rdy=0.

## Structure

- The opcode defines (LB, LH, LW, LBU, LHU contiguous, then SB, SH, SW) and IO_BASE live in the shared config.vh; the ROB uses the same ranges.
- One sub-module, load_extender, is natural: a combinational block taking opcode + 32-bit raw data and producing the extended result.

## Test plan

- LW at 0x100 holding bytes 78 56 34 12, gnt immediate → done after 7 cycles with done_l_data=0x12345678 and index echoed.
- LB at 0x101 with byte 0x80 → done_l_data=0xFFFFFF80; LBU at the same address → 0x00000080.
- SH addr 0x200, s_val 0xABCD1234 → exactly two writes (0x200:0x34, 0x201:0x12), then done with data 0.
- SB to 0x30000 with io_buffer_full high 5 cycles → mem_wr stays low for those cycles, then one write; done after 8 cycles.
- mem_gnt withheld 3 cycles → mem_req high with no access; timing then shifts by exactly 3.
- rst asserted in the second write cycle of an SW → outputs at their reset values next cycle, no done pulse, and a new request is accepted afterward.
